// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: debounce FSM states and frame result codes.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } kp_state_e;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } frame_res_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner_db.sv
// Matrix keypad scanner: one-hot row strobes, per-frame key census and
// frame-level press/release debounce with a stable accepted key code.
module keypad_scanner_db
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [COLS-1:0]               col,
    output logic [ROWS-1:0]               row,
    output logic [ROWS+COLS-1:0]          key_code,
    output logic [$clog2(ROWS*COLS)-1:0]  key_index,
    output logic                          key_valid,
    output logic                          key_release,
    output logic                          key_held,
    output logic                          multi_key
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int IW = $clog2(ROWS*COLS);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int NW = $clog2(DEBOUNCE_FRAMES+1);
    localparam logic [NW-1:0] DB_N = NW'(DEBOUNCE_FRAMES);

    logic [COLS-1:0] w_col;

    sync_2ff #(.WIDTH(COLS)) u_col_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (col),
        .o_q   (w_col)
    );

    // ---------------- scan timing ----------------
    logic [DW-1:0]   r_div;
    logic [RW-1:0]   r_row_idx;
    logic [ROWS-1:0] r_row;
    logic            w_sample;
    logic            w_frame_end;

    assign w_sample    = (r_div == DW'(SCAN_DIV-1));
    assign w_frame_end = w_sample && (r_row_idx == RW'(ROWS-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div     <= '0;
            r_row_idx <= '0;
            r_row     <= ROWS'(1);
        end else if (w_sample) begin
            r_div     <= '0;
            r_row_idx <= (r_row_idx == RW'(ROWS-1)) ? '0 : r_row_idx + RW'(1);
            r_row     <= {r_row[ROWS-2:0], r_row[ROWS-1]};
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    assign row = r_row;

    // ---------------- frame accumulation ----------------
    logic [1:0]    r_acc_cnt;
    logic [RW-1:0] r_acc_row;
    logic [CW-1:0] r_acc_col;
    logic [1:0]    w_row_cnt;
    logic [CW-1:0] w_row_first;
    logic [2:0]    w_sum;
    logic [1:0]    w_tot;
    logic [RW-1:0] w_f_row;
    logic [CW-1:0] w_f_col;
    frame_res_e    w_res;

    always_comb begin
        w_row_cnt   = '0;
        w_row_first = '0;
        // descending scan so the lowest pressed column wins
        for (int c = COLS-1; c >= 0; c--)
            if (w_col[c]) w_row_first = CW'(c);
        for (int c = 0; c < COLS; c++)
            if (w_col[c] && (w_row_cnt != 2'd2)) w_row_cnt = w_row_cnt + 2'd1;
        w_sum = {1'b0, r_acc_cnt} + {1'b0, w_row_cnt};
        w_tot = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
        if (r_acc_cnt == 2'd0) begin
            w_f_row = r_row_idx;
            w_f_col = w_row_first;
        end else begin
            w_f_row = r_acc_row;
            w_f_col = r_acc_col;
        end
        case (w_tot)
            2'd0:    w_res = NONE;
            2'd1:    w_res = SINGLE;
            default: w_res = MULTI;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_cnt <= '0;
            r_acc_row <= '0;
            r_acc_col <= '0;
        end else if (w_frame_end) begin
            r_acc_cnt <= '0;
            r_acc_row <= '0;
            r_acc_col <= '0;
        end else if (w_sample) begin
            r_acc_cnt <= w_tot;
            r_acc_row <= w_f_row;
            r_acc_col <= w_f_col;
        end
    end

    // ---------------- debounce FSM ----------------
    kp_state_e     r_state, w_state_nx;
    logic [NW-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
    logic [RW-1:0] r_cand_row, w_cand_row_nx;
    logic [CW-1:0] r_cand_col, w_cand_col_nx;
    logic          w_same;
    logic          w_accept;
    logic          w_release;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_cand_row <= '0;
            r_cand_col <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_cand_row <= w_cand_row_nx;
            r_cand_col <= w_cand_col_nx;
        end
    end

    assign w_cnt_inc = r_cnt + NW'(1);
    assign w_same    = (w_res == SINGLE) && (w_f_row == r_cand_row) && (w_f_col == r_cand_col);

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_cand_row_nx = r_cand_row;
        w_cand_col_nx = r_cand_col;
        if (w_frame_end) begin
            case (r_state)
                IDLE: if (w_res == SINGLE) begin
                    w_cand_row_nx = w_f_row;
                    w_cand_col_nx = w_f_col;
                    w_cnt_nx      = NW'(1);
                    w_state_nx    = (DB_N == NW'(1)) ? HELD : PRESS_CHK;
                end
                PRESS_CHK: if (w_same) begin
                    w_cnt_nx = w_cnt_inc;
                    if (w_cnt_inc == DB_N) w_state_nx = HELD;
                end else if (w_res == SINGLE) begin
                    w_cand_row_nx = w_f_row;
                    w_cand_col_nx = w_f_col;
                    w_cnt_nx      = NW'(1);
                end else begin
                    w_cnt_nx   = '0;
                    w_state_nx = IDLE;
                end
                HELD: if (w_res == NONE) begin
                    w_cnt_nx   = NW'(1);
                    w_state_nx = (DB_N == NW'(1)) ? IDLE : REL_CHK;
                end
                REL_CHK: if (w_res == NONE) begin
                    w_cnt_nx = w_cnt_inc;
                    if (w_cnt_inc == DB_N) w_state_nx = IDLE;
                end else begin
                    w_state_nx = HELD;
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        w_accept  = w_frame_end && (r_state == IDLE || r_state == PRESS_CHK) && (w_state_nx == HELD);
        w_release = w_frame_end && (r_state == HELD || r_state == REL_CHK) && (w_state_nx == IDLE);
    end

    // ---------------- registered outputs ----------------
    logic [ROWS+COLS-1:0] r_key_code, w_code_nx;
    logic [IW-1:0]        r_key_index;
    logic                 r_key_valid, r_key_release, r_key_held, r_multi;

    always_comb begin
        w_code_nx = '0;
        w_code_nx[ROWS+COLS-1-int'(w_f_row)] = 1'b1;
        w_code_nx[COLS-1-int'(w_f_col)]      = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_code    <= '0;
            r_key_index   <= '0;
            r_key_valid   <= 1'b0;
            r_key_release <= 1'b0;
            r_key_held    <= 1'b0;
            r_multi       <= 1'b0;
        end else begin
            r_key_valid   <= w_accept;
            r_key_release <= w_release;
            if (w_accept) begin
                r_key_code  <= w_code_nx;
                r_key_index <= IW'(int'(w_f_row) * COLS + int'(w_f_col));
                r_key_held  <= 1'b1;
            end else if (w_release) begin
                r_key_held  <= 1'b0;
            end
            if (w_frame_end) r_multi <= (w_res == MULTI);
        end
    end

    assign key_code    = r_key_code;
    assign key_index   = r_key_index;
    assign key_valid   = r_key_valid;
    assign key_release = r_key_release;
    assign key_held    = r_key_held;
    assign multi_key   = r_multi;

endmodule
